// File: rtl/fa_using_structural.sv
// fa_using_structural: ripple chain of gate-level full adders, registered result.
// Optional FA_SELF_CHECK_EN compares the chain against a behavioural sum.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   in_valid        a/b/cin qualify this cycle
//   a, b [WIDTH]    operands
//   cin             carry into bit 0
//   sum [WIDTH]     registered sum (holds when in_valid=0)
//   cout            registered carry out of bit WIDTH-1
//   out_valid       sum/cout hold the result of an in_valid cycle
//   err             chain/reference mismatch (0 when FA_SELF_CHECK_EN undefined)
module fa_using_structural #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid,
  output logic             err
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] t;

  assign c[0] = cin;

  // Each cell: two half adders (p/s and g/t) joined by an OR for carry.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    xor u_x0 (p[i], a[i], b[i]);
    xor u_x1 (s[i], p[i], c[i]);
    and u_a0 (g[i], a[i], b[i]);
    and u_a1 (t[i], p[i], c[i]);
    or  u_o0 (c[i+1], g[i], t[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum  <= s;
        cout <= c[WIDTH];
      end
    end
  end

`ifdef FA_SELF_CHECK_EN
  logic [WIDTH:0] ref_sum;

  assign ref_sum = {1'b0, a} + {1'b0, b}
                 + {{WIDTH{1'b0}}, cin};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (in_valid) begin
      err <= ({c[WIDTH], s} != ref_sum);
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fa_using_structural.sv
// tb_fa_using_structural: scoreboard bench for WIDTH=1 and WIDTH=8 instances.
// Expected results come from integer addition; a negedge monitor pops and checks.
module tb_fa_using_structural;

  typedef struct {
    int         due;
    logic       v;
    logic [7:0] s;
    logic       c;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       iv1 = 1'b0;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       c1 = 1'b0;
  logic [0:0] sum1;
  logic       cout1;
  logic       ov1;
  logic       err1;
  logic       iv8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       c8 = 1'b0;
  logic [7:0] sum8;
  logic       cout8;
  logic       ov8;
  logic       err8;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic in_rst = 1'b1;

  exp_t q1[$];
  exp_t q8[$];

  logic       h1s = 1'b0;
  logic       h1c = 1'b0;
  logic [7:0] h8s = '0;
  logic       h8c = 1'b0;

  fa_using_structural #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1),
    .a(a1), .b(b1), .cin(c1),
    .sum(sum1), .cout(cout1),
    .out_valid(ov1), .err(err1)
  );

  fa_using_structural #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8),
    .a(a8), .b(b8), .cin(c8),
    .sum(sum8), .cout(cout8),
    .out_valid(ov8), .err(err8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL timeout: run did not finish, got cyc=%0d want <50000", cyc);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic ov,
                     input logic [7:0] os, input logic oc,
                     input logic oe, input exp_t e);
    n_cmp++;
    if ({ov, os, oc, oe} !== {e.v, e.s, e.c, 1'b0}) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got v=%b s=%h c=%b err=%b want v=%b s=%h c=%b err=0",
               nm, cyc, ov, os, oc, oe, e.v, e.s, e.c);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!in_rst) begin
      while (q1.size() > 0 && q1[0].due <= cyc) begin
        e = q1.pop_front();
        chk("w1", ov1, {7'b0, sum1}, cout1, err1, e);
      end
      while (q8.size() > 0 && q8[0].due <= cyc) begin
        e = q8.pop_front();
        chk("w8", ov8, sum8, cout8, err8, e);
      end
    end
  end

  task automatic step(input logic v1, input logic [2:0] abc,
                      input logic v8, input logic [7:0] x,
                      input logic [7:0] y, input logic ci);
    int r;
    @(posedge clk);
    #1;
    iv1 = v1;
    a1  = abc[2];
    b1  = abc[1];
    c1  = abc[0];
    iv8 = v8;
    a8  = x;
    b8  = y;
    c8  = ci;
    if (v1) begin
      r = int'(abc[2]) + int'(abc[1]) + int'(abc[0]);
      h1s = r[0];
      h1c = r[1];
    end
    if (v8) begin
      r = int'(x) + int'(y) + int'(ci);
      h8s = r[7:0];
      h8c = r[8];
    end
    q1.push_back('{cyc + 1, v1, {7'b0, h1s}, h1c});
    q8.push_back('{cyc + 1, v8, h8s, h8c});
  endtask

  task automatic chk_zero(input string nm);
    exp_t z;
    z = '{0, 1'b0, 8'h00, 1'b0};
    chk({nm, "_w1"}, ov1, {7'b0, sum1}, cout1, err1, z);
    chk({nm, "_w8"}, ov8, sum8, cout8, err8, z);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst_n  = 1'b1;
    in_rst = 1'b0;

    // directed WIDTH=1 sequence
    step(1, 3'b000, 0, 8'h00, 8'h00, 1'b0);
    step(1, 3'b100, 0, 8'h00, 8'h00, 1'b0);
    step(1, 3'b110, 0, 8'h00, 8'h00, 1'b0);
    step(1, 3'b110, 0, 8'h00, 8'h00, 1'b0);
    step(1, 3'b010, 0, 8'h00, 8'h00, 1'b0);
    step(1, 3'b011, 0, 8'h00, 8'h00, 1'b0);

    // exhaustive WIDTH=1
    for (int i = 0; i < 8; i++)
      step(1, 3'(i), 0, 8'h00, 8'h00, 1'b0);

    // WIDTH=8 boundaries
    step(0, 3'b000, 1, 8'hFF, 8'h00, 1'b1);
    step(0, 3'b000, 1, 8'h7F, 8'h01, 1'b0);
    step(1, 3'b111, 1, 8'hFF, 8'hFF, 1'b1);

    // idle hold
    for (int i = 0; i < 3; i++)
      step(0, 3'b000, 0, 8'h12, 8'h34, 1'b1);

    // reset while a result is pending
    step(1, 3'b011, 1, 8'hAA, 8'h55, 1'b1);
    #3;
    in_rst = 1'b1;
    rst_n  = 1'b0;
    q1.delete();
    q8.delete();
    h1s = 1'b0;
    h1c = 1'b0;
    h8s = '0;
    h8c = 1'b0;
    #1;
    chk_zero("rst_async");
    @(posedge clk);
    #1;
    chk_zero("rst_edge");
    @(negedge clk);
    iv1    = 1'b0;
    iv8    = 1'b0;
    rst_n  = 1'b1;
    in_rst = 1'b0;
    step(0, 3'b000, 0, 8'h00, 8'h00, 1'b0);
    step(0, 3'b000, 0, 8'h00, 8'h00, 1'b0);

    // random vectors, back-to-back
    for (int i = 0; i < 1000; i++)
      step(1'($urandom), 3'($urandom_range(0, 7)),
           1'b1, 8'($urandom), 8'($urandom), 1'($urandom));

    step(0, 3'b000, 0, 8'h00, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (q1.size() + q8.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d entries left want 0",
               q1.size() + q8.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
